// File: rtl/num_scan_ctrl_if.sv
// Bus-side and display-side signal bundle for the seven-segment scan controller.
interface num_scan_ctrl_if;
    logic [31:0] num_data;
    logic        num_we;
    logic        blank_lz;
    logic [7:0]  num_csn;
    logic [6:0]  num_a_g;
    logic        frame_done;

    modport master (
        output num_data,
        output num_we,
        output blank_lz,
        input  num_csn,
        input  num_a_g,
        input  frame_done
    );

    modport slave (
        input  num_data,
        input  num_we,
        input  blank_lz,
        output num_csn,
        output num_a_g,
        output frame_done
    );
endinterface

// File: rtl/num_scan_ctrl.sv
// Seven-segment scan controller: eight hex digits time-multiplexed onto an
// 8-digit display, with double-buffered updates committed at frame boundaries.
module num_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 10000
) (
    input  logic           clk,
    input  logic           resetn,
    num_scan_ctrl_if.slave bus
);
    localparam logic [15:0] LP_LAST = 16'(SCAN_DIV - 1);

    logic [31:0] r_pend;
    logic        r_pend_v;
    logic [31:0] r_disp;
    logic [15:0] r_cnt;
    logic [2:0]  r_dig;
    logic [7:0]  r_csn;
    logic [6:0]  r_a_g;

    logic        w_slot_end;
    logic        w_frame_end;
    logic [31:0] w_shifted;
    logic        w_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h7E;
            4'h1: pat = 7'h30;
            4'h2: pat = 7'h6D;
            4'h3: pat = 7'h79;
            4'h4: pat = 7'h33;
            4'h5: pat = 7'h5B;
            4'h6: pat = 7'h5F;
            4'h7: pat = 7'h70;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h7B;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h1F;
            4'hC: pat = 7'h4E;
            4'hD: pat = 7'h3D;
            4'hE: pat = 7'h4F;
            default: pat = 7'h47;
        endcase
        return pat;
    endfunction

    assign w_slot_end  = (r_cnt == LP_LAST);
    assign w_frame_end = w_slot_end && (r_dig == 3'd7);

    // Current digit's nibble sits at the bottom; zero shifted value means
    // this digit and every more-significant one are zero.
    assign w_shifted = r_disp >> {r_dig, 2'b00};
    assign w_blank   = bus.blank_lz && (r_dig != 3'd0) && (w_shifted == '0);

    assign bus.frame_done = w_frame_end;
    assign bus.num_csn    = r_csn;
    assign bus.num_a_g    = r_a_g;

    // Prescaler and digit pointer advance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
            r_dig <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_dig <= r_dig + 3'd1;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Pending/committed buffers; a write in the boundary cycle re-arms pending
    // after the old pending value has been committed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_disp   <= '0;
        end else begin
            if (w_frame_end && r_pend_v) begin
                r_disp   <= r_pend;
                r_pend_v <= 1'b0;
            end
            if (bus.num_we) begin
                r_pend   <= bus.num_data;
                r_pend_v <= 1'b1;
            end
        end
    end

    // Registered digit select and segment pattern, with leading-zero blanking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_csn <= '1;
            r_a_g <= '0;
        end else if (w_blank) begin
            r_csn <= '1;
            r_a_g <= '0;
        end else begin
            r_csn <= ~(8'b1 << r_dig);
            r_a_g <= seg_decode(w_shifted[3:0]);
        end
    end
endmodule

// File: tb/tb_num_scan_ctrl.sv
// Randomized and directed bench for num_scan_ctrl, checked against a
// cycle-count based reference model of the display behaviour.
module tb_num_scan_ctrl;
    localparam int unsigned D     = 4;
    localparam int unsigned FRAME = 8 * D;

    logic clk;
    logic resetn;

    num_scan_ctrl_if bus_if ();

    num_scan_ctrl #(.SCAN_DIV(D)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp;
    int unsigned n_err;

    // Reference model state: edges since reset release, buffers, expected outputs.
    int unsigned m_t;
    logic [31:0] m_pend;
    logic        m_pv;
    logic [31:0] m_disp;
    logic [7:0]  m_csn;
    logic [6:0]  m_ag;

    logic [6:0] seg_tab [16];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s t=%0d got=%h expected=%h", tag, m_t, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_t    = 0;
        m_pend = '0;
        m_pv   = 1'b0;
        m_disp = '0;
        m_csn  = 8'hFF;
        m_ag   = 7'h00;
    endtask

    // Check current outputs, advance the model across one edge, then move to
    // 1 time unit after that edge.
    task automatic step();
        int unsigned d;
        logic [31:0] sh;
        logic        boundary;
        boundary = ((m_t % FRAME) == FRAME - 1);
        check_val("frame_done", 32'(bus_if.frame_done), 32'(boundary));
        check_val("num_csn", 32'(bus_if.num_csn), 32'(m_csn));
        check_val("num_a_g", 32'(bus_if.num_a_g), 32'(m_ag));
        d  = (m_t / D) % 8;
        sh = m_disp >> (4 * d);
        if (bus_if.blank_lz && d != 0 && sh == 0) begin
            m_csn = 8'hFF;
            m_ag  = 7'h00;
        end else begin
            m_csn = 8'hFF ^ 8'(1 << d);
            m_ag  = seg_tab[sh[3:0]];
        end
        if (boundary && m_pv) begin
            m_disp = m_pend;
            m_pv   = 1'b0;
        end
        if (bus_if.num_we) begin
            m_pend = bus_if.num_data;
            m_pv   = 1'b1;
        end
        m_t++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step();
    endtask

    task automatic write_word(input logic [31:0] data);
        bus_if.num_data = data;
        bus_if.num_we   = 1'b1;
        step();
        bus_if.num_we   = 1'b0;
    endtask

    task automatic goto_phase(input int unsigned ph);
        while ((m_t % FRAME) != ph) step();
    endtask

    initial begin
        seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
        n_cmp = 0;
        n_err = 0;
        bus_if.num_data = '0;
        bus_if.num_we   = 1'b0;
        bus_if.blank_lz = 1'b0;
        resetn = 1'b0;
        model_reset();

        // Reset held across edges.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_csn", 32'(bus_if.num_csn), 32'h0000_00FF);
        check_val("rst_a_g", 32'(bus_if.num_a_g), 32'h0000_0000);
        check_val("rst_fd", 32'(bus_if.frame_done), 32'h0);
        resetn = 1'b1;

        // First edge after release: digit 0 showing 0, then plain scan order.
        step();
        check_val("first_csn", 32'(bus_if.num_csn), 32'h0000_00FE);
        check_val("first_a_g", 32'(bus_if.num_a_g), 32'h0000_007E);
        run(2 * FRAME);

        // Mid-frame write becomes visible only from the next frame.
        goto_phase(10);
        write_word(32'h1234_5678);
        run(2 * FRAME);

        // Write coincident with the frame boundary lands one frame later.
        goto_phase(5);
        write_word(32'hAAAA_AAAA);
        goto_phase(FRAME - 1);
        write_word(32'h0000_BEEF);
        run(2 * FRAME + 3);

        // Leading-zero blanking on a value with a zero top.
        bus_if.blank_lz = 1'b1;
        write_word(32'h0000_0F00);
        run(2 * FRAME + 5);

        // All-zero with blanking, then blanking switched off mid-frame.
        write_word(32'h0000_0000);
        run(2 * FRAME);
        goto_phase(13);
        bus_if.blank_lz = 1'b0;
        run(FRAME + 2);

        // Random writes, data with random leading zeros, blank toggles.
        for (int unsigned i = 0; i < 1200; i++) begin
            bus_if.num_we   = ($urandom_range(0, 7) == 0);
            bus_if.num_data = $urandom >> (4 * $urandom_range(0, 8));
            if ($urandom_range(0, 15) == 0) bus_if.blank_lz = ~bus_if.blank_lz;
            step();
        end
        bus_if.num_we = 1'b0;

        // Asynchronous reset mid-frame with a write still pending.
        goto_phase(9);
        write_word(32'h8765_4321);
        run(2);
        resetn = 1'b0;
        #2;
        check_val("async_csn", 32'(bus_if.num_csn), 32'h0000_00FF);
        check_val("async_a_g", 32'(bus_if.num_a_g), 32'h0000_0000);
        check_val("async_fd", 32'(bus_if.frame_done), 32'h0);
        @(posedge clk);
        #1;
        check_val("async_hold_csn", 32'(bus_if.num_csn), 32'h0000_00FF);
        resetn = 1'b1;
        model_reset();
        bus_if.blank_lz = 1'b0;
        run(3 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
